// File: rtl/serial_shift_rx_if.sv
// Bundle of the four serial display wires plus the reconstructed frame and
// status outputs of the serial shift receiver.
interface serial_shift_rx_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 7
);
  logic             s_clk;
  logic             s_dat;
  logic             s_clrn;
  logic             s_pen;
  logic [WIDTH-1:0] data_out;
  logic             frame_valid;
  logic             len_err;
  logic             overrun;
  logic             busy;
  logic [CNTW-1:0]  bit_cnt;

  modport master (
    output s_clk, s_dat, s_clrn, s_pen,
    input  data_out, frame_valid, len_err, overrun, busy, bit_cnt
  );

  modport slave (
    input  s_clk, s_dat, s_clrn, s_pen,
    output data_out, frame_valid, len_err, overrun, busy, bit_cnt
  );
endinterface

// File: rtl/serial_shift_rx.sv
// Oversampling receiver for the 4-wire shift-out display link: rebuilds the
// parallel frame a shift-register chain would present and flags bad frames.
module serial_shift_rx #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 7
) (
  input  logic             clk,
  input  logic             RSTN,
  serial_shift_rx_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(WIDTH + 1);

  // Pipes: [0] metastability flop, [1] synchronized value, [2] previous value.
  logic [2:0] clk_pipe;
  logic [2:0] pen_pipe;
  logic [1:0] dat_pipe;
  logic [1:0] clrn_pipe;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [CNTW-1:0]  cnt;
  logic             ovr;
  logic [WIDTH-1:0] data_q;
  logic             fv_q;
  logic             len_q;

  logic             clk_rise;
  logic             pen_rise;
  logic             clr_active;
  logic             dat_sync;
  logic [WIDTH-1:0] sr_next;
  logic [CNTW-1:0]  cnt_next;
  logic             ovr_next;
  logic             latch;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      clk_pipe  <= '0;
      pen_pipe  <= '0;
      dat_pipe  <= '0;
      clrn_pipe <= '0;
    end else begin
      clk_pipe  <= {clk_pipe[1:0], bus.s_clk};
      pen_pipe  <= {pen_pipe[1:0], bus.s_pen};
      dat_pipe  <= {dat_pipe[0], bus.s_dat};
      clrn_pipe <= {clrn_pipe[0], bus.s_clrn};
    end
  end

  assign clk_rise   = clk_pipe[1] & ~clk_pipe[2];
  assign pen_rise   = pen_pipe[1] & ~pen_pipe[2];
  assign clr_active = ~clrn_pipe[1];
  assign dat_sync   = dat_pipe[1];

  // The shift result is computed first so that a coincident s_pen rise
  // latches a frame that already includes this cycle's bit.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    ovr_next = ovr;
    if (clk_rise) begin
      sr_next = {sr[WIDTH-2:0], dat_sync};
      if (cnt != CNT_SAT) begin
        cnt_next = cnt + CNTW'(1);
      end
      if (cnt >= CNT_FULL) begin
        ovr_next = 1'b1;
      end
    end
    latch = pen_rise && (cnt_next != '0);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
      data_q <= '0;
      fv_q   <= 1'b0;
      len_q  <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (clr_active) begin
        state <= IDLE;
        sr    <= '0;
        cnt   <= '0;
        ovr   <= 1'b0;
      end else if (latch) begin
        data_q <= sr_next;
        fv_q   <= 1'b1;
        len_q  <= (cnt_next != CNT_FULL);
        state  <= IDLE;
        sr     <= '0;
        cnt    <= '0;
        ovr    <= 1'b0;
      end else begin
        sr  <= sr_next;
        cnt <= cnt_next;
        ovr <= ovr_next;
        if (clk_rise) begin
          state <= SHIFT;
        end
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.len_err     = len_q;
  assign bus.overrun     = ovr;
  assign bus.busy        = (state == SHIFT);
  assign bus.bit_cnt     = cnt;

endmodule

// File: tb/tb_serial_shift_rx.sv
// Self-checking bench: a 16-bit and a 64-bit receiver share one serial stream.
module tb_serial_shift_rx;

  logic clk = 1'b0;
  logic rstn;
  logic s_clk, s_dat, s_clrn, s_pen;

  int checks   = 0;
  int failures = 0;
  int p16 = 0;
  int p64 = 0;
  logic [63:0] prev16;

  serial_shift_rx_if #(.WIDTH(16), .CNTW(7)) if16 ();
  serial_shift_rx_if #(.WIDTH(64), .CNTW(7)) if64 ();

  assign if16.s_clk  = s_clk;
  assign if16.s_dat  = s_dat;
  assign if16.s_clrn = s_clrn;
  assign if16.s_pen  = s_pen;
  assign if64.s_clk  = s_clk;
  assign if64.s_dat  = s_dat;
  assign if64.s_clrn = s_clrn;
  assign if64.s_pen  = s_pen;

  serial_shift_rx #(.WIDTH(16), .CNTW(7)) dut16 (.clk(clk), .RSTN(rstn), .bus(if16.slave));
  serial_shift_rx #(.WIDTH(64), .CNTW(7)) dut64 (.clk(clk), .RSTN(rstn), .bus(if64.slave));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if16.frame_valid === 1'b1) p16++;
    if (if64.frame_valid === 1'b1) p64++;
  end

  typedef struct {
    logic [63:0] bits;
    int          n;
    bit          coincide;
    logic [15:0] exp_data;
    logic        exp_len;
    logic        exp_ovr;
    int          exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_dat = b;
    s_clk = 1'b0;
    tick(5);
    s_clk = 1'b1;
    tick(5);
  endtask

  // Shifts n bits MSB-first; with coincide the last s_clk rise is left for
  // the caller to pair with the s_pen rise.
  task automatic send_frame(input logic [63:0] bits, input int n, input bit coincide);
    for (int i = n - 1; i >= 0; i--) begin
      if (coincide && i == 0) begin
        s_dat = bits[i];
        s_clk = 1'b0;
        tick(5);
        s_clk = 1'b1;
      end else begin
        send_bit(bits[i]);
      end
    end
  endtask

  task automatic pen_latch(input string nm, input bit wide, input logic [63:0] exp_data,
                           input logic exp_len);
    int p0;
    p0 = wide ? p64 : p16;
    s_pen = 1'b1;
    tick(3);
    if (wide) begin
      chk({nm, ".fv64"},   64'(if64.frame_valid), 64'd1);
      chk({nm, ".data64"}, if64.data_out, exp_data);
      chk({nm, ".len64"},  64'(if64.len_err), 64'(exp_len));
    end else begin
      chk({nm, ".fv"},   64'(if16.frame_valid), 64'd1);
      chk({nm, ".data"}, 64'(if16.data_out), exp_data);
      chk({nm, ".len"},  64'(if16.len_err), 64'(exp_len));
    end
    tick(1);
    chk({nm, ".fv_low"}, 64'(wide ? if64.frame_valid : if16.frame_valid), 64'd0);
    s_pen = 1'b0;
    tick(3);
    if (!wide) begin
      chk({nm, ".cnt_clr"}, 64'(if16.bit_cnt), 64'd0);
      chk({nm, ".ovr_clr"}, 64'(if16.overrun), 64'd0);
      chk({nm, ".busy_clr"}, 64'(if16.busy), 64'd0);
      prev16 = exp_data;
    end
    chk({nm, ".pulses"}, 64'((wide ? p64 : p16) - p0), 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [63:0] rb;
    int          rn;
    bit          rco;
    int          p0;

    vecs[0] = '{64'hA5C3,  16, 1'b0, 16'hA5C3, 1'b0, 1'b0, 16};
    vecs[1] = '{64'h7FFF,  15, 1'b0, 16'h7FFF, 1'b1, 1'b0, 15};
    vecs[2] = '{64'h1234,  16, 1'b0, 16'h1234, 1'b0, 1'b0, 16};
    vecs[3] = '{64'h1BEEF, 17, 1'b0, 16'hBEEF, 1'b1, 1'b1, 17};
    vecs[4] = '{64'h3FFFF, 18, 1'b0, 16'hFFFF, 1'b1, 1'b1, 17};
    vecs[5] = '{64'hC0DE,  16, 1'b1, 16'hC0DE, 1'b0, 1'b0, 16};
    vecs[6] = '{64'h1,      1, 1'b0, 16'h0001, 1'b1, 1'b0, 1};

    rstn = 1'b0; s_clk = 1'b0; s_dat = 1'b0; s_clrn = 1'b1; s_pen = 1'b0;
    prev16 = '0;
    tick(3);
    chk("rst.data",  64'(if16.data_out), 64'd0);
    chk("rst.fv",    64'(if16.frame_valid), 64'd0);
    chk("rst.len",   64'(if16.len_err), 64'd0);
    chk("rst.ovr",   64'(if16.overrun), 64'd0);
    chk("rst.busy",  64'(if16.busy), 64'd0);
    chk("rst.cnt",   64'(if16.bit_cnt), 64'd0);
    chk("rst.data64", if64.data_out, 64'd0);
    rstn = 1'b1;
    tick(5);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].bits, vecs[v].n, vecs[v].coincide);
      if (!vecs[v].coincide) begin
        chk($sformatf("vec%0d.cnt", v),  64'(if16.bit_cnt), 64'(vecs[v].exp_cnt));
        chk($sformatf("vec%0d.ovr", v),  64'(if16.overrun), 64'(vecs[v].exp_ovr));
        chk($sformatf("vec%0d.busy", v), 64'(if16.busy), 64'd1);
        chk($sformatf("vec%0d.hold", v), 64'(if16.data_out), prev16);
      end
      pen_latch($sformatf("vec%0d", v), 1'b0, 64'(vecs[v].exp_data), vecs[v].exp_len);
    end

    // Clear mid-frame: s_clk edges during the clear must be ignored.
    send_frame(64'hAB, 8, 1'b0);
    chk("clr.cnt8", 64'(if16.bit_cnt), 64'd8);
    s_clrn = 1'b0;
    tick(10);
    chk("clr.cnt",  64'(if16.bit_cnt), 64'd0);
    chk("clr.busy", 64'(if16.busy), 64'd0);
    chk("clr.hold", 64'(if16.data_out), prev16);
    chk("clr.len",  64'(if16.len_err), 64'd1);
    send_bit(1'b1);
    chk("clr.ign",  64'(if16.bit_cnt), 64'd0);
    s_clrn = 1'b1;
    tick(4);
    send_frame(64'h00FF, 16, 1'b0);
    pen_latch("clr_ff", 1'b0, 64'h00FF, 1'b0);
    p0 = p16;
    s_pen = 1'b1;
    tick(6);
    s_pen = 1'b0;
    tick(3);
    chk("empty.pulses", 64'(p16 - p0), 64'd0);
    chk("empty.data",   64'(if16.data_out), 64'h00FF);
    chk("empty.len",    64'(if16.len_err), 64'd0);

    // Reset mid-frame acts immediately, then a clean frame follows.
    send_frame(64'h15, 5, 1'b0);
    chk("mid.cnt5", 64'(if16.bit_cnt), 64'd5);
    #2;
    rstn = 1'b0;
    s_clk = 1'b0;
    #1;
    chk("arst.data", 64'(if16.data_out), 64'd0);
    chk("arst.cnt",  64'(if16.bit_cnt), 64'd0);
    chk("arst.busy", 64'(if16.busy), 64'd0);
    chk("arst.len",  64'(if16.len_err), 64'd0);
    tick(2);
    rstn = 1'b1;
    prev16 = '0;
    tick(5);
    send_frame(64'hFFFF, 16, 1'b0);
    pen_latch("post_rst", 1'b0, 64'hFFFF, 1'b0);

    send_frame(64'h0123456789ABCDEF, 64, 1'b0);
    chk("w64.cnt",  64'(if64.bit_cnt), 64'd64);
    chk("w64.ovr",  64'(if64.overrun), 64'd0);
    pen_latch("w64", 1'b1, 64'h0123456789ABCDEF, 1'b0);

    // Random frames against a reference: the register holds the last 16 bits sent.
    for (int r = 0; r < 24; r++) begin
      rn  = int'($urandom_range(1, 20));
      rco = ($urandom_range(0, 3) == 0);
      rb  = {$urandom, $urandom};
      rb  = rb & ((64'd1 << rn) - 64'd1);
      send_frame(rb, rn, rco);
      if (!rco) begin
        chk($sformatf("rnd%0d.cnt", r), 64'(if16.bit_cnt), 64'((rn > 17) ? 17 : rn));
        chk($sformatf("rnd%0d.ovr", r), 64'(if16.overrun), 64'(rn > 16));
      end
      pen_latch($sformatf("rnd%0d", r), 1'b0, {48'd0, rb[15:0]}, (rn != 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
